// File: rtl/force_net_arbiter.sv
// rtl/force_net_arbiter.sv - two-level force/release net resolution with queued commands

// Per-channel command FIFO; ready is purely occupancy based, so a full queue
// never accepts a push even when a pop happens in the same cycle.
module force_net_cmd_queue #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  input  logic         push_op,
  input  logic [W-1:0] push_data,
  output logic         ready,
  input  logic         pop,
  output logic         not_empty,
  output logic         head_op,
  output logic [W-1:0] head_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign ready     = (count != FULL_CNT);
  assign not_empty = (count != '0);
  assign do_push   = push_valid && ready;
  assign do_pop    = pop && not_empty;
  assign head_op   = mem[rd_ptr][W];
  assign head_data = mem[rd_ptr][W-1:0];

  // Storage write; entries need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_op, push_data};
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

module force_net_arbiter #(
  parameter int           W         = 8,
  parameter int           CMD_DEPTH = 2,
  parameter int           NET_KIND  = 1,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] drv_value,
  input  logic         drv_we,
  input  logic         apply_en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_op,
  input  logic [W-1:0] in_data,
  input  logic         out_valid,
  output logic         out_ready,
  input  logic         out_op,
  input  logic [W-1:0] out_data,
  output logic [W-1:0] net_value,
  output logic         inner_active,
  output logic         outer_active,
  output logic         net_changed
);
  logic         in_ne, in_hop;
  logic [W-1:0] in_hdata;
  logic         out_ne, out_hop;
  logic [W-1:0] out_hdata;

  logic [W-1:0] inner_val, outer_val;
  logic         held;
  logic [W-1:0] held_val;

  logic         n_in_act, n_out_act, n_held, released;
  logic [W-1:0] n_in_val, n_out_val, n_held_val, next_net;

  force_net_cmd_queue #(.W(W), .DEPTH(CMD_DEPTH)) u_in_q (
    .clk(clk), .rst_n(rst_n),
    .push_valid(in_valid), .push_op(in_op), .push_data(in_data), .ready(in_ready),
    .pop(apply_en), .not_empty(in_ne), .head_op(in_hop), .head_data(in_hdata)
  );

  force_net_cmd_queue #(.W(W), .DEPTH(CMD_DEPTH)) u_out_q (
    .clk(clk), .rst_n(rst_n),
    .push_valid(out_valid), .push_op(out_op), .push_data(out_data), .ready(out_ready),
    .pop(apply_en), .not_empty(out_ne), .head_op(out_hop), .head_data(out_hdata)
  );

  // Post-apply force state, hold-on-release behaviour and priority resolution.
  always_comb begin
    n_in_act   = inner_active;
    n_in_val   = inner_val;
    n_out_act  = outer_active;
    n_out_val  = outer_val;
    n_held     = held;
    n_held_val = held_val;
    released   = 1'b0;

    if (apply_en && in_ne) begin
      if (in_hop) begin
        n_in_act = 1'b1;
        n_in_val = in_hdata;
      end else if (inner_active) begin
        n_in_act = 1'b0;
        released = 1'b1;
      end
    end

    if (apply_en && out_ne) begin
      if (out_hop) begin
        n_out_act = 1'b1;
        n_out_val = out_hdata;
      end else if (outer_active) begin
        n_out_act = 1'b0;
        released  = 1'b1;
      end
    end

    // Variable semantics: a release that would expose the driver keeps the
    // last net value until the driver writes again; a same-edge write wins.
    if (NET_KIND == 0) begin
      if (drv_we) begin
        n_held = 1'b0;
      end else if (released && !n_out_act && !n_in_act && !held) begin
        n_held     = 1'b1;
        n_held_val = net_value;
      end
    end

    if (n_out_act)     next_net = n_out_val;
    else if (n_in_act) next_net = n_in_val;
    else if (n_held)   next_net = n_held_val;
    else               next_net = drv_value;
  end

  // Register force state, resolved net and its change pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner_active <= 1'b0;
      outer_active <= 1'b0;
      inner_val    <= '0;
      outer_val    <= '0;
      held         <= 1'b0;
      held_val     <= '0;
      net_value    <= RESET_VAL;
      net_changed  <= 1'b0;
    end else begin
      inner_active <= n_in_act;
      outer_active <= n_out_act;
      inner_val    <= n_in_val;
      outer_val    <= n_out_val;
      held         <= n_held;
      held_val     <= n_held_val;
      net_value    <= next_net;
      net_changed  <= (next_net != net_value);
    end
  end
endmodule

// File: doc/force_net_arbiter.md
Name: force_net_arbiter

Overview:
- Registered resolution stage that sits directly downstream of a driving submodule and produces the net value seen by the enclosing scope.
- Models two-level force/release semantics in synthesizable form:
  - an inner force, applied at the submodule output;
  - an outer force, applied at the parent-level net, which overrides everything.
- Each level takes queued force/release commands that are committed only on apply strobes, so a bench can schedule overrides at exact cycles.

Parameters:
- W, 8, width of driven value and net.
- CMD_DEPTH, 2, command queue depth per channel (power of two, ≥2).
- NET_KIND, 1, 1 = net semantics (release reverts immediately); 0 = variable semantics (release retains last value until next driver write).
- RESET_VAL, 0, net_value after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- drv_value  input  W  value from upstream driver.
- drv_we  input  1  driver update strobe; used in NET_KIND=0 only.
- apply_en  input  1  commit strobe; pops at most one command per channel.
- in_valid  input  1  inner command valid.
- in_ready  output  1  inner queue not full.
- in_op  input  1  1 = force, 0 = release.
- in_data  input  W  inner force value.
- out_valid  input  1  outer command valid.
- out_ready  output  1  outer queue not full.
- out_op  input  1  1 = force, 0 = release.
- out_data  input  W  outer force value.
- net_value  output  W  resolved registered net.
- inner_active  output  1  inner force in effect.
- outer_active  output  1  outer force in effect.
- net_changed  output  1  one-cycle pulse when net_value changed at this edge.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - net_value = RESET_VAL;
  - inner_active, outer_active, net_changed = 0;
  - held flag = 0;
  - both queues empty, so in_ready and out_ready = 1 once rst_n is released.
- Reset asserted mid-operation discards queued commands and active forces immediately.
- Queues:
  - push on valid && ready;
  - ready = !full, combinational from occupancy; no pass-through when full, even if a pop occurs that cycle;
  - a command pushed in cycle N is never applied in cycle N; earliest application is the next apply_en edge;
  - FIFO order; pointers wrap modulo CMD_DEPTH;
  - pop only when apply_en = 1 and queue is non-empty.
- Applying a force (op = 1): set the level's active flag, load its value. A force while already active replaces the value.
- Applying a release (op = 0) while active: clear the active flag.
  - NET_KIND = 0 only: if the resulting resolution would fall through to the driver, set held and capture the pre-release net_value as held_val.
- A release while not active is a no-op.
- Both channels may apply in the same edge; both state updates take effect and priority resolves the output.
- Resolution, evaluated from post-update state each edge, registered into net_value. First match wins:
  1. outer_active → outer value
  2. inner_active → inner value
  3. held → held_val
  4. otherwise → drv_value
- Latency: one cycle from the apply edge or drv_value change to net_value.
- held clears on a drv_we edge. drv_we in the same edge as a release wins: held stays 0 and drv_value is used.
- In NET_KIND = 1, held is never set and drv_we is ignored.
- net_changed = 1 for one cycle exactly when the newly registered net_value differs from the previous one.
- inner_active and outer_active are registered, reflecting post-apply state.

Test Plan:
1. Reset, drv_value = 0x11, apply_en idle → net_value = 0x11 after 1 cycle; net_changed pulses once; both active flags 0.
2. Inner force 0x01 queued then applied → net 0x01, inner_active = 1. Outer force 0x10 applied → net 0x10. Outer release → net 0x01. Inner release → net 0x11, with exactly one net_changed pulse per step.
3. Push 3 inner commands with apply_en = 0 and CMD_DEPTH = 2 → in_ready = 0 after the 2nd; 3rd accepted only after an apply_en pop; commands apply in order.
4. Inner and outer force (0x22, 0x33) applied in the same edge → net 0x33, both active. Outer release → 0x22.
5. NET_KIND = 0: inner force 0x5A, release, drv_value changed to 0x77 without drv_we → net stays 0x5A. drv_we pulse → net 0x77 next cycle.
6. rst_n asserted while outer force is active and queues are non-empty → net_value = RESET_VAL asynchronously; flags clear; ready = 1 once rst_n is released; stale commands are never applied.
